axi_lite_regfile: RTL and testbench

Parametrised AXI4-Lite slave exposing a bank of `NUM_REGS` memory-mapped registers with byte-strobe writes, per-register read-only masking, and SLVERR on illegal accesses. It is the general-purpose control/status block sitting between the AXI-Lite interconnect and the SDIO datapath. Hardware drives the read-only registers; software owns the read-write registers.

---
 rtl/axi_lite_pkg.sv | 35 +++
 rtl/axi_lite_wr_chan.sv | 135 +++++++++++++
 rtl/axi_lite_regfile.sv | 192 +++++++++++++++++++
 tb/tb_axi_lite_regfile.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module  : axi_lite_pkg
// Purpose : Shared constants, FSM state encodings and a constant-evaluable
//           ceil(log2) helper for the AXI4-Lite register file.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {
        WR_COLLECT = 1'b0,  // filling the AW / W holding slots
        WR_RESP    = 1'b1   // bvalid high, waiting for bready
    } wr_state_e;

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,     // arready high
        RD_DATA = 1'b1      // rvalid high, waiting for rready
    } rd_state_e;

    // ceil(log2(value)); clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage : axi_lite_pkg
`default_nettype wire

// File: rtl/axi_lite_wr_chan.sv
`default_nettype none
// ============================================================================
// Module  : axi_lite_wr_chan
// Purpose : AXI4-Lite write side: independent AW and W holding slots, the
//           write-response FSM and the B channel. When both slots are full it
//           raises commit_o for one cycle with the decoded register index,
//           data and byte strobes; the register array answers with
//           commit_ok_i, which selects OKAY or SLVERR for the response.
// Ports   : axi_clk / axi_resetn            clock, async active-low reset
//           axi_aw* / axi_w* / axi_b*       AXI4-Lite write channels
//           commit_o, commit_idx_o,
//           commit_data_o, commit_strb_o    commit request to register array
//           commit_ok_i                     target is an in-range RW register
// Revision: 1.0 - initial release
// ============================================================================
module axi_lite_wr_chan
    import axi_lite_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int ADDR_LSB = 2,
    parameter int IDX_W    = ADDR_W - ADDR_LSB
) (
    input  logic                axi_clk,
    input  logic                axi_resetn,
    input  logic [ADDR_W-1:0]   axi_awaddr,
    input  logic                axi_awvalid,
    output logic                axi_awready,
    input  logic [DATA_W-1:0]   axi_wdata,
    input  logic [DATA_W/8-1:0] axi_wstrb,
    input  logic                axi_wvalid,
    output logic                axi_wready,
    output logic [1:0]          axi_bresp,
    output logic                axi_bvalid,
    input  logic                axi_bready,
    output logic                commit_o,
    output logic [IDX_W-1:0]    commit_idx_o,
    output logic [DATA_W-1:0]   commit_data_o,
    output logic [DATA_W/8-1:0] commit_strb_o,
    input  logic                commit_ok_i
);

    wr_state_e             state_q, state_d;
    logic                  aw_full_q, aw_full_d;
    logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
    logic                  w_full_q, w_full_d;
    logic [DATA_W-1:0]     w_data_q, w_data_d;
    logic [DATA_W/8-1:0]   w_strb_q, w_strb_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;

    // Sub-word address bits carry no register selection.
    logic unused_awaddr_lsb;
    assign unused_awaddr_lsb = ^axi_awaddr[ADDR_LSB-1:0];

    always_comb begin
        state_d   = state_q;
        aw_full_d = aw_full_q;
        aw_idx_d  = aw_idx_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bresp_d   = bresp_q;
        commit_o  = 1'b0;

        if (axi_awvalid && awready_q) begin
            aw_full_d = 1'b1;
            aw_idx_d  = axi_awaddr[ADDR_W-1:ADDR_LSB];
        end
        if (axi_wvalid && wready_q) begin
            w_full_d = 1'b1;
            w_data_d = axi_wdata;
            w_strb_d = axi_wstrb;
        end

        case (state_q)
            WR_COLLECT: begin
                // The readies are low while a slot is full, so no new
                // handshake can collide with the commit cycle.
                if (aw_full_q && w_full_q) begin
                    commit_o  = 1'b1;
                    bresp_d   = commit_ok_i ? RESP_OKAY : RESP_SLVERR;
                    aw_full_d = 1'b0;
                    w_full_d  = 1'b0;
                    state_d   = WR_RESP;
                end
            end
            WR_RESP: begin
                if (axi_bready) begin
                    state_d = WR_COLLECT;
                end
            end
            default: state_d = WR_COLLECT;
        endcase

        // Readies are registered copies of the next-state acceptance rule.
        awready_d = !aw_full_d && (state_d == WR_COLLECT);
        wready_d  = !w_full_d  && (state_d == WR_COLLECT);
    end

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q   <= WR_COLLECT;
            aw_full_q <= 1'b0;
            aw_idx_q  <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= RESP_OKAY;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_full_q <= aw_full_d;
            aw_idx_q  <= aw_idx_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bresp_q   <= bresp_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
        end
    end

    assign axi_awready   = awready_q;
    assign axi_wready    = wready_q;
    assign axi_bvalid    = (state_q == WR_RESP);
    assign axi_bresp     = bresp_q;
    assign commit_idx_o  = aw_idx_q;
    assign commit_data_o = w_data_q;
    assign commit_strb_o = w_strb_q;

endmodule : axi_lite_wr_chan
`default_nettype wire

// File: rtl/axi_lite_regfile.sv
`default_nettype none
// ============================================================================
// Module  : axi_lite_regfile
// Purpose : AXI4-Lite slave with NUM_REGS memory-mapped registers. RW
//           registers are written under byte strobes; RO registers (RO_MASK)
//           return hw_rd_in on reads and reject writes with SLVERR, as do
//           out-of-range indices. Read and write paths are independent.
// Ports   : axi_clk / axi_resetn   clock, async active-low reset
//           axi_aw*/w*/b*          write channels (via axi_lite_wr_chan)
//           axi_ar*/r*             read channels
//           reg_out                flat register contents, reg i at
//                                  [i*DATA_W +: DATA_W]
//           hw_rd_in               hardware values for RO registers
//           reg_wr_pulse           one-cycle strobe per successful write
// Revision: 1.0 - initial release
// ============================================================================
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int                  DATA_W   = 32,
    parameter int                  ADDR_W   = 32,
    parameter int                  NUM_REGS = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
    input  logic                         axi_clk,
    input  logic                         axi_resetn,
    input  logic [ADDR_W-1:0]            axi_awaddr,
    input  logic                         axi_awvalid,
    output logic                         axi_awready,
    input  logic [DATA_W-1:0]            axi_wdata,
    input  logic [DATA_W/8-1:0]          axi_wstrb,
    input  logic                         axi_wvalid,
    output logic                         axi_wready,
    output logic [1:0]                   axi_bresp,
    output logic                         axi_bvalid,
    input  logic                         axi_bready,
    input  logic [ADDR_W-1:0]            axi_araddr,
    input  logic                         axi_arvalid,
    output logic                         axi_arready,
    output logic [DATA_W-1:0]            axi_rdata,
    output logic [1:0]                   axi_rresp,
    output logic                         axi_rvalid,
    input  logic                         axi_rready,
    output logic [NUM_REGS*DATA_W-1:0]   reg_out,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_rd_in,
    output logic [NUM_REGS-1:0]          reg_wr_pulse
);

    localparam int ADDR_LSB = clog2(DATA_W / 8);
    localparam int IDX_W    = ADDR_W - ADDR_LSB;
    localparam int NBYTES   = DATA_W / 8;

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    logic                commit;
    logic [IDX_W-1:0]    commit_idx;
    logic [DATA_W-1:0]   commit_data;
    logic [NBYTES-1:0]   commit_strb;
    logic                commit_ok;

    axi_lite_wr_chan #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ADDR_LSB (ADDR_LSB),
        .IDX_W    (IDX_W)
    ) u_wr_chan (
        .axi_clk       (axi_clk),
        .axi_resetn    (axi_resetn),
        .axi_awaddr    (axi_awaddr),
        .axi_awvalid   (axi_awvalid),
        .axi_awready   (axi_awready),
        .axi_wdata     (axi_wdata),
        .axi_wstrb     (axi_wstrb),
        .axi_wvalid    (axi_wvalid),
        .axi_wready    (axi_wready),
        .axi_bresp     (axi_bresp),
        .axi_bvalid    (axi_bvalid),
        .axi_bready    (axi_bready),
        .commit_o      (commit),
        .commit_idx_o  (commit_idx),
        .commit_data_o (commit_data),
        .commit_strb_o (commit_strb),
        .commit_ok_i   (commit_ok)
    );

    // ------------------------------------------------------------------
    // Register array
    // ------------------------------------------------------------------
    // Packed so that the flat reg_out layout falls out directly.
    logic [NUM_REGS-1:0][DATA_W-1:0] reg_q, reg_d;
    logic [NUM_REGS-1:0]             pulse_q, pulse_d;

    always_comb begin
        commit_ok = 1'b0;
        reg_d     = reg_q;
        pulse_d   = '0;
        // Matching against every legal index doubles as the range check.
        for (int i = 0; i < NUM_REGS; i++) begin
            if ((commit_idx == IDX_W'(i)) && !RO_MASK[i]) begin
                commit_ok = 1'b1;
                if (commit) begin
                    pulse_d[i] = 1'b1;
                    for (int b = 0; b < NBYTES; b++) begin
                        if (commit_strb[b]) begin
                            reg_d[i][b*8 +: 8] = commit_data[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            reg_q   <= '0;
            pulse_q <= '0;
        end else begin
            reg_q   <= reg_d;
            pulse_q <= pulse_d;
        end
    end

    assign reg_out      = reg_q;
    assign reg_wr_pulse = pulse_q;

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    rd_state_e          rd_state_q, rd_state_d;
    logic               arready_q, arready_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [1:0]         rresp_q, rresp_d;
    logic [IDX_W-1:0]   ar_idx;

    assign ar_idx = axi_araddr[ADDR_W-1:ADDR_LSB];

    // hw_rd_in slices of RW registers and sub-word address bits are unused.
    logic unused_rd_inputs;
    assign unused_rd_inputs = ^{hw_rd_in, axi_araddr[ADDR_LSB-1:0]};

    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (axi_arvalid && arready_q) begin
                    // Sampled from reg_q, so a same-edge commit is not seen.
                    rdata_d = '0;
                    rresp_d = RESP_SLVERR;
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (ar_idx == IDX_W'(i)) begin
                            rresp_d = RESP_OKAY;
                            rdata_d = RO_MASK[i] ? hw_rd_in[i*DATA_W +: DATA_W]
                                                 : reg_q[i];
                        end
                    end
                    rd_state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (axi_rready) begin
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
        arready_d = (rd_state_d == RD_IDLE);
    end

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign axi_arready = arready_q;
    assign axi_rvalid  = (rd_state_q == RD_DATA);
    assign axi_rdata   = rdata_q;
    assign axi_rresp   = rresp_q;

endmodule : axi_lite_regfile
`default_nettype wire

// File: tb/tb_axi_lite_regfile.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi_lite_regfile
// Purpose : Self-checking bench for axi_lite_regfile (8 x 32-bit registers,
//           register 0 read-only). Table of single transactions followed by
//           hand-written multi-cycle sequences.
// Revision: 1.0 - initial release
// ============================================================================
module tb_axi_lite_regfile;

    localparam int          NR   = 8;
    localparam logic [1:0]  OKAY = 2'b00;
    localparam logic [1:0]  SERR = 2'b10;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [31:0]       awaddr = '0;
    logic              awvalid = 1'b0;
    logic              awready;
    logic [31:0]       wdata = '0;
    logic [3:0]        wstrb = '0;
    logic              wvalid = 1'b0;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready = 1'b0;
    logic [31:0]       araddr = '0;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready = 1'b0;
    logic [NR*32-1:0]  reg_out;
    logic [NR*32-1:0]  hw_rd_in;
    logic [NR-1:0]     reg_wr_pulse;

    int errors = 0;
    int checks = 0;
    logic [31:0] m [NR];

    always #5 clk = ~clk;

    axi_lite_regfile #(
        .DATA_W   (32),
        .ADDR_W   (32),
        .NUM_REGS (NR),
        .RO_MASK  (8'h01)
    ) dut (
        .axi_clk      (clk),
        .axi_resetn   (resetn),
        .axi_awaddr   (awaddr),
        .axi_awvalid  (awvalid),
        .axi_awready  (awready),
        .axi_wdata    (wdata),
        .axi_wstrb    (wstrb),
        .axi_wvalid   (wvalid),
        .axi_wready   (wready),
        .axi_bresp    (bresp),
        .axi_bvalid   (bvalid),
        .axi_bready   (bready),
        .axi_araddr   (araddr),
        .axi_arvalid  (arvalid),
        .axi_arready  (arready),
        .axi_rdata    (rdata),
        .axi_rresp    (rresp),
        .axi_rvalid   (rvalid),
        .axi_rready   (rready),
        .reg_out      (reg_out),
        .hw_rd_in     (hw_rd_in),
        .reg_wr_pulse (reg_wr_pulse)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_regs(input string name);
        for (int i = 0; i < NR; i++) begin
            chk($sformatf("%s reg_out[%0d]", name, i), 64'(reg_out[i*32 +: 32]), 64'(m[i]));
        end
    endtask

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int idx;
        idx = int'(addr >> 2);
        if (idx >= 1 && idx < NR) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) m[idx][b*8 +: 8] = data[b*8 +: 8];
            end
        end
    endtask

    // Entered and left on a negedge. AW and W are offered in the same cycle.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] resp, output logic [7:0] pulse, output int lat);
        bit aw_done, w_done;
        int n;
        awaddr = addr; awvalid = 1'b1;
        wdata = data; wstrb = strb; wvalid = 1'b1;
        aw_done = 0; w_done = 0; n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            if (awvalid && awready) aw_done = 1;
            if (wvalid && wready) w_done = 1;
            @(negedge clk); n++;
            if (aw_done) awvalid = 1'b0;
            if (w_done) wvalid = 1'b0;
        end
        if (!(aw_done && w_done)) chk("write handshake timeout", 64'(n), 64'(0));
        awvalid = 1'b0; wvalid = 1'b0;
        lat = 0;
        while (!bvalid && lat < 20) begin
            @(negedge clk); lat++;
        end
        resp = bresp;
        pulse = reg_wr_pulse;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output int lat);
        int n;
        araddr = addr; arvalid = 1'b1; n = 0;
        while (!arready && n < 20) begin
            @(negedge clk); n++;
        end
        if (!arready) chk("read handshake timeout", 64'(n), 64'(0));
        @(negedge clk);
        arvalid = 1'b0;
        lat = 0;
        while (!rvalid && lat < 20) begin
            @(negedge clk); lat++;
        end
        data = rdata;
        resp = rresp;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    typedef struct {
        bit          is_rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [15];

    initial begin
        logic [1:0]  resp;
        logic [7:0]  pulse;
        logic [31:0] rd;
        int          lat;
        int          n;
        bit          hold_ok;
        logic [1:0]  bresp0;

        vecs[0]  = '{0, 32'h04,   32'hDEADBEEF, 4'hF, OKAY, 32'h0};
        vecs[1]  = '{1, 32'h04,   32'h0,        4'h0, OKAY, 32'hDEADBEEF};
        vecs[2]  = '{0, 32'h08,   32'hAABBCCDD, 4'hF, OKAY, 32'h0};
        vecs[3]  = '{1, 32'h08,   32'h0,        4'h0, OKAY, 32'hAABBCCDD};
        vecs[4]  = '{0, 32'h00,   32'h12345678, 4'hF, SERR, 32'h0};
        vecs[5]  = '{1, 32'h00,   32'h0,        4'h0, OKAY, 32'h0000CAFE};
        vecs[6]  = '{0, 32'h20,   32'hFFFFFFFF, 4'hF, SERR, 32'h0};
        vecs[7]  = '{1, 32'h20,   32'h0,        4'h0, SERR, 32'h0};
        vecs[8]  = '{0, 32'h0C,   32'h000000FF, 4'h1, OKAY, 32'h0};
        vecs[9]  = '{1, 32'h0F,   32'h0,        4'h0, OKAY, 32'h000000FF};
        vecs[10] = '{0, 32'h1C,   32'h87654321, 4'h8, OKAY, 32'h0};
        vecs[11] = '{1, 32'h1C,   32'h0,        4'h0, OKAY, 32'h87000000};
        vecs[12] = '{0, 32'h1E,   32'h0000AB00, 4'h2, OKAY, 32'h0};
        vecs[13] = '{1, 32'h1D,   32'h0,        4'h0, OKAY, 32'h8700AB00};
        vecs[14] = '{1, 32'h1000, 32'h0,        4'h0, SERR, 32'h0};

        for (int i = 0; i < NR; i++) begin
            m[i] = '0;
            hw_rd_in[i*32 +: 32] = 32'h5A5A0000 | 32'(i);
        end
        hw_rd_in[31:0] = 32'h0000CAFE;

        // ---- reset state ----
        repeat (2) @(negedge clk);
        chk("reset awready", 64'(awready), 64'(0));
        chk("reset wready", 64'(wready), 64'(0));
        chk("reset arready", 64'(arready), 64'(0));
        chk("reset bvalid", 64'(bvalid), 64'(0));
        chk("reset rvalid", 64'(rvalid), 64'(0));
        chk("reset bresp/rresp", 64'({bresp, rresp}), 64'(0));
        chk("reset rdata", 64'(rdata), 64'(0));
        chk("reset pulse", 64'(reg_wr_pulse), 64'(0));
        chk_regs("reset");
        resetn = 1'b1;
        @(negedge clk);
        chk("readies after release", 64'({awready, wready, arready}), 64'(3'b111));

        // ---- table-driven single transactions ----
        for (int v = 0; v < 15; v++) begin
            if (vecs[v].is_rd) begin
                do_read(vecs[v].addr, rd, resp, lat);
                chk($sformatf("vec%0d rresp", v), 64'(resp), 64'(vecs[v].resp));
                chk($sformatf("vec%0d rdata", v), 64'(rd), 64'(vecs[v].rdata));
                chk($sformatf("vec%0d rd latency", v), 64'(lat), 64'(0));
            end else begin
                do_write(vecs[v].addr, vecs[v].data, vecs[v].strb, resp, pulse, lat);
                if (vecs[v].resp == OKAY) model_write(vecs[v].addr, vecs[v].data, vecs[v].strb);
                chk($sformatf("vec%0d bresp", v), 64'(resp), 64'(vecs[v].resp));
                chk($sformatf("vec%0d wr latency", v), 64'(lat), 64'(1));
                chk($sformatf("vec%0d pulse", v), 64'(pulse),
                    (vecs[v].resp == OKAY) ? (64'(1) << (vecs[v].addr >> 2)) : 64'(0));
                chk($sformatf("vec%0d pulse drop", v), 64'(reg_wr_pulse), 64'(0));
                chk_regs($sformatf("vec%0d", v));
            end
        end

        // ---- W three cycles before AW, partial strobe onto reg2 ----
        wdata = 32'h11223344; wstrb = 4'h5; wvalid = 1'b1;
        chk("early W wready", 64'(wready), 64'(1));
        @(negedge clk); wvalid = 1'b0;
        @(negedge clk);
        chk("W slot full wready", 64'(wready), 64'(0));
        @(negedge clk);
        awaddr = 32'h08; awvalid = 1'b1;
        chk("late AW awready", 64'(awready), 64'(1));
        @(negedge clk); awvalid = 1'b0;
        chk("bvalid not yet", 64'(bvalid), 64'(0));
        @(negedge clk);
        m[2] = 32'hAA22CC44;
        chk("early W bvalid", 64'(bvalid), 64'(1));
        chk("early W bresp", 64'(bresp), 64'(OKAY));
        chk("early W pulse", 64'(reg_wr_pulse), 64'(8'h04));
        chk_regs("early W");
        bready = 1'b1; @(negedge clk); bready = 1'b0;

        // ---- write commit and AR on the same edge: read sees old value ----
        awaddr = 32'h04; awvalid = 1'b1; wdata = 32'h0BADF00D; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'h04; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        m[1] = 32'h0BADF00D;
        chk("same-edge rvalid", 64'(rvalid), 64'(1));
        chk("same-edge rdata old", 64'(rdata), 64'(32'hDEADBEEF));
        chk("same-edge bvalid", 64'(bvalid), 64'(1));
        chk_regs("same-edge");
        rready = 1'b1; bready = 1'b1;
        @(negedge clk);
        rready = 1'b0; bready = 1'b0;

        // ---- bready held low: write side stalls, reads continue ----
        awaddr = 32'h0C; awvalid = 1'b1; wdata = 32'h33333333; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        chk("hold bvalid", 64'(bvalid), 64'(1));
        m[3] = 32'h33333333;
        bresp0 = bresp;
        hold_ok = 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (awready || wready || !bvalid || bresp !== bresp0) hold_ok = 0;
        end
        chk("hold readies low, bresp stable", 64'(hold_ok), 64'(1));
        do_read(32'h04, rd, resp, lat);
        chk("hold read rdata", 64'(rd), 64'(32'h0BADF00D));
        chk("hold read latency", 64'(lat), 64'(0));
        chk("hold still stalled", 64'({awready, wready, bvalid}), 64'(3'b001));
        chk("hold bresp", 64'(bresp), 64'(OKAY));
        bready = 1'b1; @(negedge clk); bready = 1'b0;
        @(negedge clk);
        chk("hold released readies", 64'({awready, wready}), 64'(2'b11));
        chk_regs("hold");

        // ---- reset with bvalid and rvalid high ----
        awaddr = 32'h10; awvalid = 1'b1; wdata = 32'h44444444; wstrb = 4'hF; wvalid = 1'b1;
        araddr = 32'h04; arvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(negedge clk);
        chk("pre-reset valids", 64'({bvalid, rvalid}), 64'(2'b11));
        resetn = 1'b0;
        #1;
        for (int i = 0; i < NR; i++) m[i] = '0;
        chk("mid reset bvalid/rvalid", 64'({bvalid, rvalid}), 64'(0));
        chk("mid reset pulse", 64'(reg_wr_pulse), 64'(0));
        chk_regs("mid reset");
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        do_write(32'h14, 32'h00000055, 4'hF, resp, pulse, lat);
        m[5] = 32'h00000055;
        chk("post-reset bresp", 64'(resp), 64'(OKAY));
        chk("post-reset pulse", 64'(pulse), 64'(8'h20));
        do_read(32'h14, rd, resp, lat);
        chk("post-reset rdata", 64'(rd), 64'(32'h55));
        do_read(32'h04, rd, resp, lat);
        chk("post-reset reg1 cleared", 64'(rd), 64'(0));
        chk_regs("post-reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_axi_lite_regfile
`default_nettype wire
